adc_spi_sampler: RTL and testbench
==================================

# adc_spi_sampler

Tick-paced ADC front end. Each `tick_i` pulse from the tick generator starts one conversion on an external SPI-style ADC: it asserts `cnv_o` for a fixed conversion time, then clocks `DATA_WIDTH` bits in MSB-first on `miso_i` and presents the word on `data_o` with a one-cycle `valid_o`. It sits between the tick generator and the downstream sample-processing chain. Ticks that arrive while a conversion is in flight are dropped and flagged.

## Interface
- `DATA_WIDTH`, 16: bits per sample. Must be ≥ 2.
- `CONV_CYCLES`, 30: clock cycles `cnv_o` is held high. Must be ≥ 1.
- `SCK_HALF`, 2: clock cycles per SCK half-period. Must be ≥ 1.
- `clk_i` input 1: system clock. The block has this one clock only.
- `reset_ni` input 1: asynchronous, active-low reset.
- `tick_i` input 1: conversion request, one-cycle pulse.
- `miso_i` input 1: ADC serial data, already synchronised to `clk_i`.
- `cnv_o` output 1: ADC convert strobe, registered.
- `sck_o` output 1: ADC serial clock, registered, idle low.
- `data_o` output DATA_WIDTH: last completed sample, unsigned, held between updates.
- `valid_o` output 1: one-cycle pulse when `data_o` updates.
- `overrun_o` output 1: one-cycle pulse when a tick was dropped.

## Operation
- States: IDLE, CONVERT, SHIFT, DONE.
- IDLE:
  - `tick_i`=1 → CONVERT.
  - `cnv_o` is driven 1 from the next cycle.
  - Conversion-time counter and bit counter load 0.
- CONVERT:
  - `cnv_o`=1 for exactly CONV_CYCLES cycles, then → SHIFT.
  - `cnv_o` goes 0 on the SHIFT entry edge.
- SHIFT generates DATA_WIDTH SCK periods:
  - Each period is `sck_o`=0 for SCK_HALF cycles, then `sck_o`=1 for SCK_HALF cycles.
  - `miso_i` is sampled on the clk edge that drives `sck_o` from 1 to 0. That is the last cycle of each high phase.
  - Sampled bits shift into an internal register, MSB first.
  - After the DATA_WIDTH-th sample, `sck_o`=0 and the state → DONE.
- DONE:
  - `data_o` ← shift register and `valid_o`=1 for this one cycle.
  - Next state is IDLE unconditionally.
- Overrun:
  - Applies when `tick_i`=1 in CONVERT, SHIFT or DONE.
  - The tick is ignored and `overrun_o`=1 in the following cycle.
  - The in-flight conversion is unaffected.
- `data_o` changes only in DONE. The shift register is never visible mid-frame.
- Counter widths are sized with `$clog2` of their maximum value. No wrap-around is possible within a frame.

## Timing
- Reset (`reset_ni`=0, asynchronous) forces all of the following immediately, in any state:
  - state to IDLE;
  - `cnv_o`, `sck_o`, `valid_o` and `overrun_o` to 0;
  - `data_o` to 0;
  - all counters and the shift register to 0.
- Reset mid-frame discards the partial sample. No `valid_o` is produced for it.
- Latency:
  - Tick seen in IDLE at cycle T.
  - `cnv_o` is high for cycles T+1 … T+CONV_CYCLES.
  - SHIFT spans T+CONV_CYCLES+1 … T+CONV_CYCLES+2·SCK_HALF·DATA_WIDTH.
  - `valid_o` is high at T+CONV_CYCLES+2·SCK_HALF·DATA_WIDTH+1. With defaults this is T+95.
- Earliest accepted next tick: T+CONV_CYCLES+2·SCK_HALF·DATA_WIDTH+2, when the block is back in IDLE. With defaults this is T+96.
  - Minimum overrun-free tick period is therefore 96 cycles.
  - A tick every 101 cycles never overruns.
- A tick in the same cycle as the DONE `valid_o` pulse is an overrun.
- Exactly DATA_WIDTH rising edges of `sck_o` occur per frame. Each high phase lasts exactly SCK_HALF cycles.

## Test plan
- **Single conversion:** reset, tick at T, ADC model drives 0xA5C3 MSB-first, changing `miso_i` after each `sck_o` rise.
  - `cnv_o` high for exactly 30 cycles.
  - 16 `sck_o` rises.
  - `valid_o` at T+95 with `data_o`=0xA5C3.
  - `overrun_o` never asserts.
- **Boundary words:** frames of 0x0000, then 0xFFFF, then 0x8001.
  - `data_o` matches each word.
  - `data_o` holds 0x8001 unchanged for 200 idle cycles after the final `valid_o`.
- **Overrun:** tick at T, extra ticks at T+10 (CONVERT), T+60 (SHIFT) and T+95 (DONE).
  - `overrun_o` pulses at T+11, T+61 and T+96.
  - One frame only; its result is unaffected.
- **Back-to-back:** tick at T and at T+96.
  - Both accepted, no overrun.
  - Second `cnv_o` rises at T+97.
  - Second `valid_o` at T+191.
- **Periodic:** ticks every 101 cycles for 10 frames with an incrementing ADC pattern.
  - 10 `valid_o` pulses with correct data.
  - Zero overruns.
- **Reset mid-SHIFT:** drop `reset_ni` at T+50 for 3 cycles.
  - Outputs go to 0 asynchronously, within the same cycle.
  - No `valid_o` for the aborted frame.
  - The next tick yields a correct frame.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler
//   Tick-paced front end for an SPI-style ADC. Each accepted tick_i starts
//   one frame: cnv_o is held high for CONV_CYCLES cycles, then DATA_WIDTH
//   SCK periods clock the sample in MSB-first on miso_i. The finished word
//   appears on data_o together with a one-cycle valid_o pulse. A tick that
//   arrives while a frame is in flight is dropped and flagged on overrun_o.
//
// Ports
//   clk_i      system clock
//   reset_ni   asynchronous active-low reset
//   tick_i     conversion request (one-cycle pulse)
//   miso_i     ADC serial data, already synchronous to clk_i
//   cnv_o      ADC convert strobe (registered)
//   sck_o      ADC serial clock (registered, idle low)
//   data_o     last completed sample, held between updates
//   valid_o    one-cycle pulse when data_o updates
//   overrun_o  one-cycle pulse, the cycle after a dropped tick
//   state_o    current FSM state, for debug and checker binding
//
// Handshake: valid_o is a push-only strobe. There is no ready; downstream
// logic must capture data_o in the cycle valid_o is high, and data_o then
// holds until the next valid_o.
module adc_spi_sampler #(
  parameter int DATA_WIDTH  = 16,
  parameter int CONV_CYCLES = 30,
  parameter int SCK_HALF    = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  tick_i,
  input  logic                  miso_i,
  output logic                  cnv_o,
  output logic                  sck_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overrun_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // +1 keeps every counter at least one bit wide when a parameter is 1.
  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int HALF_W = $clog2(SCK_HALF + 1);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  state_t                r_state;
  logic [CONV_W-1:0]     r_conv_cnt;
  logic [HALF_W-1:0]     r_half_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_cnv;
  logic                  r_sck;
  logic                  r_valid;
  logic                  r_overrun;

  // Shift register plus the bit being sampled this cycle. Only the low
  // DATA_WIDTH-1 bits need storing; the last bit goes straight to data_o.
  logic [DATA_WIDTH-1:0] w_next_word;
  assign w_next_word = {r_shift, miso_i};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= S_IDLE;
      r_conv_cnt <= '0;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_cnv      <= 1'b0;
      r_sck      <= 1'b0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= tick_i && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (tick_i) begin
            r_state    <= S_CONVERT;
            r_cnv      <= 1'b1;
            r_conv_cnt <= '0;
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_shift    <= '0;
            r_sck      <= 1'b0;
          end
        end
        S_CONVERT: begin
          if (r_conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
            r_state    <= S_SHIFT;
            r_cnv      <= 1'b0;
            r_half_cnt <= '0;
          end else begin
            r_conv_cnt <= r_conv_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_half_cnt == HALF_W'(SCK_HALF - 1)) begin
            r_half_cnt <= '0;
            if (r_sck) begin
              // End of a high phase: SCK falls and miso_i is captured.
              r_sck   <= 1'b0;
              r_shift <= w_next_word[DATA_WIDTH-2:0];
              if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                // Output registers load on the DONE entry edge so that
                // data_o and valid_o are both visible during DONE.
                r_state <= S_DONE;
                r_data  <= w_next_word;
                r_valid <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_sck <= 1'b1;
            end
          end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cnv_o     = r_cnv;
  assign sck_o     = r_sck;
  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;
  assign state_o   = r_state;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Testbench for adc_spi_sampler: randomized ticks and ADC words, a frame-level
// reference model (busy window, latency arithmetic) feeding expected queues,
// and a negedge monitor that pops and compares whenever the DUT presents
// valid_o or overrun_o.
module tb_adc_spi_sampler;

  localparam int W    = 16;
  localparam int CONV = 30;
  localparam int HALF = 2;
  // Tick at T -> valid_o at T + LAT; next tick accepted from T + LAT + 1.
  localparam int LAT  = CONV + 2 * HALF * W + 1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tick = 1'b0;
  logic         miso = 1'b0;
  logic         cnv;
  logic         sck;
  logic [W-1:0] data;
  logic         valid;
  logic         overrun;
  logic [1:0]   state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adc_spi_sampler #(.DATA_WIDTH(W), .CONV_CYCLES(CONV), .SCK_HALF(HALF)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .tick_i   (tick),
    .miso_i   (miso),
    .cnv_o    (cnv),
    .sck_o    (sck),
    .data_o   (data),
    .valid_o  (valid),
    .overrun_o(overrun),
    .state_o  (state)
  );

  // ---------------- scoreboard state ----------------
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           ovr_t_q[$];
  int           next_free = 0;
  int           acc_t = -1000;
  logic [W-1:0] held = '0;
  logic [W-1:0] adc_word = '0;
  int           rise_idx = 0;
  int           rises = 0;
  int           high_run = 0;
  logic         prev_sck = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act, input int exp);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // ---------------- monitor + ADC model ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cnv_window", cnv, (acc_t >= 0 && cyc >= acc_t + 1 && cyc <= acc_t + CONV));

      // ADC model: a new bit appears after each SCK rise, MSB first.
      if (cnv) begin
        rise_idx = 0;
        rises    = 0;
        high_run = 0;
      end
      if (sck && !prev_sck) begin
        miso = (rise_idx < W) ? adc_word[W-1-rise_idx] : 1'b0;
        rise_idx++;
        rises++;
      end
      if (sck) high_run++;
      else if (prev_sck) begin
        chk("sck_high_len", high_run, HALF);
        high_run = 0;
      end
      prev_sck = sck;

      if (valid) begin
        if (exp_q.size() == 0) flag("unexpected_valid", 1, 0);
        else begin
          logic [W-1:0] e;
          int           t;
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          chk("valid_cycle", cyc, t);
          chk("data", data, e);
          chk("sck_rises", rises, W);
          held = e;
        end
      end else if (exp_t_q.size() > 0 && cyc > exp_t_q[0]) begin
        flag("missing_valid", cyc, exp_t_q[0]);
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
      end
      chk("data_hold", data, held);

      if (overrun) begin
        if (ovr_t_q.size() == 0) flag("unexpected_overrun", cyc, -1);
        else chk("overrun_cycle", cyc, ovr_t_q.pop_front());
      end else if (ovr_t_q.size() > 0 && cyc > ovr_t_q[0]) begin
        flag("missing_overrun", cyc, ovr_t_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues a one-cycle tick in the current cycle and records the model's
  // prediction: a frame if the block is free, otherwise an overrun pulse.
  task automatic do_tick(input logic [W-1:0] word);
    int t;
    t = cyc;
    if (t >= next_free) begin
      adc_word = word;
      exp_q.push_back(word);
      exp_t_q.push_back(t + LAT);
      acc_t     = t;
      next_free = t + LAT + 1;
    end else begin
      ovr_t_q.push_back(t + 1);
    end
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Asserts reset away from a clock edge, checks that outputs clear at once,
  // and returns the model to its post-reset state.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    chk("rst_cnv", cnv, 0);
    chk("rst_sck", sck, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", data, 0);
    exp_q.delete();
    exp_t_q.delete();
    ovr_t_q.delete();
    next_free = 0;
    acc_t     = -1000;
    held      = '0;
    rise_idx  = 0;
    rises     = 0;
    high_run  = 0;
    prev_sck  = 1'b0;
    miso      = 1'b0;
    repeat (n) @(posedge clk);
    #3;
    reset_n = 1'b1;
    step(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] bnd[3];
    logic [W-1:0] base;
    int           t0;
    bnd[0] = 16'h0000;
    bnd[1] = 16'hFFFF;
    bnd[2] = 16'h8001;

    #2;
    do_reset(3);
    step(5);

    // Single conversion with the reference word.
    do_tick(16'hA5C3);
    step(100);

    // Boundary words, then a long idle hold on the final one.
    for (int i = 0; i < 3; i++) begin
      do_tick(bnd[i]);
      step(100);
    end
    step(200);

    // Overrun ticks in CONVERT, SHIFT and DONE.
    t0 = cyc;
    do_tick(W'($urandom));
    wait_until(t0 + 10);
    do_tick(W'($urandom));
    wait_until(t0 + 60);
    do_tick(W'($urandom));
    wait_until(t0 + LAT);
    do_tick(W'($urandom));
    step(10);

    // Back-to-back at the minimum period.
    t0 = cyc;
    do_tick(W'($urandom));
    wait_until(t0 + LAT + 1);
    do_tick(W'($urandom));
    step(100);

    // Periodic frames with an incrementing pattern.
    base = W'($urandom_range(0, 65535));
    for (int i = 0; i < 10; i++) begin
      t0 = cyc;
      do_tick(base + W'(i));
      wait_until(t0 + 101);
    end

    // Randomly spaced ticks, some landing inside a frame.
    for (int i = 0; i < 8; i++) begin
      do_tick(W'($urandom));
      step($urandom_range(20, 120));
    end
    step(100);

    // Reset in the middle of SHIFT, then a clean frame.
    t0 = cyc;
    do_tick(W'($urandom));
    wait_until(t0 + 50);
    do_reset(3);
    step(5);
    do_tick(W'($urandom));
    step(110);

    if (exp_q.size() != 0) flag("pending_valid", exp_q.size(), 0);
    if (ovr_t_q.size() != 0) flag("pending_overrun", ovr_t_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
